// File: rtl/axi_pkg.sv
// Shared types and AXI constants for the cache-line burst controller.
package axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_AW,
        WB_W,
        WB_B,
        RF_AR,
        RF_R,
        DONE
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] size_code(input int unsigned data_bits);
        return 3'($clog2(data_bits / 8));
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Counts burst handshakes modulo BEATS (a power of two) and flags the final beat.
module beat_counter #(
    parameter int BEATS = 16,
    localparam int CW   = $clog2(BEATS)
) (
    input  logic clk,
    input  logic arst,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] count_reg;

    // Natural wrap of a power-of-two counter returns it to 0 at burst end.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign last = (count_reg == CW'(BEATS - 1));

endmodule

// File: rtl/axi_burst_ctrl.sv
// Writeback/refill sequencer driving a line shift-FIFO against an AXI4 master port.
// Optional response/rlast checking is enabled by defining AXI_RESP_CHECK_EN.
module axi_burst_ctrl
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 512
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          i_req_wb,
    input  logic                          i_req_rf,
    input  logic [AXI_ADDR_WIDTH-1:0]     i_wb_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]     i_rf_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     i_fifo_word,
    output logic                          o_fifo_start_rd,
    output logic                          o_fifo_start_wr,
    output logic                          o_fifo_shift,
    output logic                          o_done,
    output logic                          o_busy,
    output logic                          o_error,
    output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
    output logic [7:0]                    o_awlen,
    output logic [2:0]                    o_awsize,
    output logic [1:0]                    o_awburst,
    output logic                          o_awvalid,
    input  logic                          i_awready,
    output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
    output logic                          o_wlast,
    output logic                          o_wvalid,
    input  logic                          i_wready,
    input  logic [1:0]                    i_bresp,
    input  logic                          i_bvalid,
    output logic                          o_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                    o_arlen,
    output logic [2:0]                    o_arsize,
    output logic [1:0]                    o_arburst,
    output logic                          o_arvalid,
    input  logic                          i_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
    input  logic [1:0]                    i_rresp,
    input  logic                          i_rlast,
    input  logic                          i_rvalid,
    output logic                          o_rready
);

    localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;

    state_t                      state_reg, state_next;
    logic                        rf_pend_reg;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_reg, araddr_reg;
    logic                        beat_last;
    logic                        leave_idle;

    assign leave_idle = (state_reg == IDLE) && (i_req_wb || i_req_rf);

    beat_counter #(.BEATS(BEATS)) u_beat_counter (
        .clk  (clk),
        .arst (arst),
        .inc  (o_fifo_shift),
        .last (beat_last)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg   <= IDLE;
            rf_pend_reg <= 1'b0;
            awaddr_reg  <= '0;
            araddr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (leave_idle) begin
                rf_pend_reg <= i_req_rf;
                awaddr_reg  <= i_wb_addr;
                araddr_reg  <= i_rf_addr;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        o_awvalid       = 1'b0;
        o_wvalid        = 1'b0;
        o_wlast         = 1'b0;
        o_bready        = 1'b0;
        o_arvalid       = 1'b0;
        o_rready        = 1'b0;
        o_fifo_start_wr = 1'b0;
        o_fifo_start_rd = 1'b0;
        o_fifo_shift    = 1'b0;
        o_done          = 1'b0;
        o_busy          = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (i_req_wb)      state_next = WB_AW;
                else if (i_req_rf) state_next = RF_AR;
            end
            WB_AW: begin
                o_awvalid       = 1'b1;
                o_fifo_start_wr = 1'b1;
                if (i_awready) state_next = WB_W;
            end
            WB_W: begin
                o_wvalid        = 1'b1;
                o_wlast         = beat_last;
                o_fifo_start_wr = 1'b1;
                o_fifo_shift    = i_wready;
                if (i_wready && beat_last) state_next = WB_B;
            end
            WB_B: begin
                o_bready        = 1'b1;
                o_fifo_start_wr = 1'b1;
                if (i_bvalid) state_next = rf_pend_reg ? RF_AR : DONE;
            end
            RF_AR: begin
                o_arvalid       = 1'b1;
                o_fifo_start_rd = 1'b1;
                if (i_arready) state_next = RF_R;
            end
            RF_R: begin
                o_rready        = 1'b1;
                o_fifo_start_rd = 1'b1;
                o_fifo_shift    = i_rvalid;
                if (i_rvalid && beat_last) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_awaddr  = awaddr_reg;
    assign o_awlen   = 8'(BEATS - 1);
    assign o_awsize  = size_code(AXI_DATA_WIDTH);
    assign o_awburst = BURST_INCR;
    assign o_araddr  = araddr_reg;
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = size_code(AXI_DATA_WIDTH);
    assign o_arburst = BURST_INCR;
    // The FIFO only shifts on a handshake, so wdata holds steady through a W stall.
    assign o_wdata   = i_fifo_word;
    assign o_wstrb   = '1;

`ifdef AXI_RESP_CHECK_EN
    logic error_reg;
    logic unused_inputs;

    // rlast must coincide exactly with the counter's final beat; early and missing both flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            error_reg <= 1'b0;
        end else if (leave_idle) begin
            error_reg <= 1'b0;
        end else if ((state_reg == WB_B && i_bvalid && i_bresp != RESP_OKAY) ||
                     (state_reg == RF_R && i_rvalid &&
                      (i_rresp != RESP_OKAY || i_rlast != beat_last))) begin
            error_reg <= 1'b1;
        end
    end

    assign o_error       = error_reg;
    assign unused_inputs = ^i_rdata;
`else
    logic unused_inputs;

    assign o_error       = 1'b0;
    assign unused_inputs = ^{i_rdata, i_bresp, i_rresp, i_rlast};
`endif

endmodule
